t07_spi_arbiter: RTL

T07_SPI_ARBITER -- requirements
Module: t07_spi_arbiter

---
 rtl/t07_spi_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/t07_spi_arbiter.sv
// Two-requester SPI master: round-robin arbitration between a TFT and a seven-seg
// client over one shared mode-0 bus, with per-burst chip-select locking.
module t07_spi_arbiter #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       dc0,
    input  logic       last0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       dc1,
    input  logic       last1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       spi_sck,
    output logic       spi_sdi,
    output logic       spi_dc,
    output logic       tft_cs,
    output logic       ssdec_ss,
    output logic       busy,
    output logic       owner
);

    // state | meaning
    // IDLE  | selects high, arbitrate when en=1
    // LOAD  | byte latched, owner acked, select low, sck low
    // SHIFT | 16 half-periods of sck, MSB first
    // HOLD  | burst locked to owner, wait for its next byte
    // GAP   | selects released for GAP_CYCLES, then back to IDLE

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic             owner_q;
    logic             favour;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       half_cnt;
    logic             sck_q;
    logic [7:0]       shreg;
    logic             dc_q;
    logic             last_q;
    logic [GAP_W-1:0] gap_cnt;

    logic grant;
    logic load_byte;
    logic sck_edge;
    logic shift_end;
    logic owner_req;
    logic sel_active;

    assign sck_edge  = (div_cnt == '0);
    assign shift_end = (state == S_SHIFT) && sck_edge && (half_cnt == 4'd15);
    assign owner_req = owner_q ? req1 : req0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant      = owner_q;
        load_byte  = 1'b0;
        sel_active = 1'b0;
        busy       = 1'b1;
        ack0       = 1'b0;
        ack1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (en && (req0 || req1)) begin
                    // simultaneous requests go to whoever was not served last
                    grant     = (req0 && req1) ? favour : req1;
                    load_byte = 1'b1;
                    state_nx  = S_LOAD;
                end
            end
            S_LOAD: begin
                sel_active = 1'b1;
                ack0       = ~owner_q;
                ack1       = owner_q;
                state_nx   = S_SHIFT;
            end
            S_SHIFT: begin
                sel_active = 1'b1;
                if (shift_end) begin
                    done0    = ~owner_q;
                    done1    = owner_q;
                    state_nx = last_q ? S_GAP : S_HOLD;
                end
            end
            S_HOLD: begin
                sel_active = 1'b1;
                if (en && owner_req) begin
                    load_byte = 1'b1;
                    state_nx  = S_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= 1'b0;
            favour   <= 1'b0;
            div_cnt  <= DIV_LOAD;
            half_cnt <= 4'd0;
            sck_q    <= 1'b0;
            shreg    <= 8'h00;
            dc_q     <= 1'b0;
            last_q   <= 1'b0;
            gap_cnt  <= GAP_LOAD;
        end else begin
            if (load_byte) begin
                owner_q <= grant;
                shreg   <= grant ? data1 : data0;
                dc_q    <= grant ? dc1 : dc0;
                last_q  <= grant ? last1 : last0;
            end
            case (state)
                S_LOAD: begin
                    div_cnt  <= DIV_LOAD;
                    half_cnt <= 4'd0;
                    sck_q    <= 1'b0;
                end
                S_SHIFT: begin
                    if (sck_edge) begin
                        div_cnt <= DIV_LOAD;
                        if (half_cnt == 4'd15) begin
                            // closing falling edge; the extra shift leaves sdi low when idle
                            sck_q <= 1'b0;
                            shreg <= {shreg[6:0], 1'b0};
                        end else begin
                            half_cnt <= half_cnt + 4'd1;
                            sck_q    <= ~sck_q;
                            if (sck_q) begin
                                shreg <= {shreg[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        gap_cnt <= GAP_LOAD;
                        favour  <= ~owner_q;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    gap_cnt <= GAP_LOAD;
                end
            endcase
        end
    end

    assign spi_sck  = sck_q;
    assign spi_sdi  = shreg[7];
    assign spi_dc   = dc_q;
    assign owner    = owner_q;
    assign tft_cs   = ~(sel_active & ~owner_q);
    assign ssdec_ss = ~(sel_active & owner_q);

endmodule
